rng_byte_packer: RTL

RNG_BYTE_PACKER -- requirements
Module: rng_byte_packer

---
 rtl/rng_pkg.sv | 7 +
 rtl/rng_byte_packer_if.sv | 11 +
 rtl/rng_sync_fifo.sv | 37 +++
 rtl/rng_byte_packer.sv | 83 ++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the RNG byte packer and its FIFO.
package rng_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic {WAIT_FIRST, HAVE_FIRST} pair_state_t;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam byte_t OVF_SAT = 8'hFF;
endpackage

// File: rtl/rng_byte_packer_if.sv
// rng_byte_packer_if: consumer-side byte stream with FIFO status.
interface rng_byte_packer_if;
    import rng_pkg::*;
    byte_t data_o;
    logic valid_o;
    logic ready_i;
    logic [4:0] level_o;
    byte_t overflow_cnt_o;
    modport master (output data_o, valid_o, level_o, overflow_cnt_o, input ready_i);
    modport slave (input data_o, valid_o, level_o, overflow_cnt_o, output ready_i);
endinterface

// File: rtl/rng_sync_fifo.sv
// rng_sync_fifo: synchronous FIFO with simultaneous push/pop allowed while full.
module rng_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic full,
    output logic empty,
    output logic [4:0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = level == 5'd0;
    assign full = level == 5'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + 5'(do_push) - 5'(do_pop);
        end
endmodule

// File: rtl/rng_byte_packer.sv
// rng_byte_packer: samples one LFSR bit per enabled cycle, packs bits MSB-first into bytes and queues them.
// Von Neumann pair debiasing is compiled in when RNG_PACKER_VN_DEBIAS_EN is defined.
module rng_byte_packer
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TAP_BIT = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic [31:0] lfsr_state_i,
    input  logic enable_i,
    rng_byte_packer_if.master bus
);
    logic sample_bit, emit, emit_bit, push, pop, full, empty;
    logic unused_lfsr;
    logic [2:0] bit_cnt;
    logic [4:0] level;
    byte_t asm_reg, push_byte, head, ovf_cnt;

    assign sample_bit = lfsr_state_i[TAP_BIT];
    assign unused_lfsr = ^lfsr_state_i;

`ifdef RNG_PACKER_VN_DEBIAS_EN
    pair_state_t state, state_n;
    logic first_bit;
    always_ff @(posedge clk_i)
        if (reset_i) begin
            state <= WAIT_FIRST;
            first_bit <= 1'b0;
        end else begin
            state <= state_n;
            if (enable_i && state == WAIT_FIRST) first_bit <= sample_bit;
        end
    // Pair 10 emits 1, 01 emits 0; equal pairs are discarded.
    always_comb begin
        state_n = state;
        emit = 1'b0;
        emit_bit = first_bit;
        if (enable_i) begin
            state_n = state == WAIT_FIRST ? HAVE_FIRST : WAIT_FIRST;
            emit = state == HAVE_FIRST && first_bit != sample_bit;
        end
    end
`else
    assign emit = enable_i;
    assign emit_bit = sample_bit;
`endif

    assign push_byte = {asm_reg[6:0], emit_bit};
    assign push = emit && bit_cnt == 3'd7;
    assign pop = bus.valid_o && bus.ready_i;

    always_ff @(posedge clk_i)
        if (reset_i) begin
            asm_reg <= '0;
            bit_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (emit) begin
                asm_reg <= push_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (push && full && !pop && ovf_cnt != OVF_SAT) ovf_cnt <= ovf_cnt + 8'd1;
        end

    rng_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fifo (
        .clk(clk_i),
        .rst(reset_i),
        .push(push),
        .pop(pop),
        .din(push_byte),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(level)
    );

    assign bus.data_o = head;
    assign bus.valid_o = !empty;
    assign bus.level_o = level;
    assign bus.overflow_cnt_o = ovf_cnt;
endmodule
